// File: rtl/mux_key_table_pkg.sv
// Shared encodings for the writable key/data table: request ops,
// response status codes and the write-side FSM states.
package mux_key_table_pkg;

  typedef enum logic [1:0] {
    OP_UPSERT = 2'b00,
    OP_DELETE = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK_UPDATE = 2'b00,
    ST_OK_ALLOC  = 2'b01,
    ST_ERR_FULL  = 2'b10,
    ST_ERR_MISS  = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_COMMIT = 2'b01,
    S_CLEAR  = 2'b10
  } state_e;

endpackage

// File: rtl/mux_key_table_slot_find.sv
// Combinational slot search: finds the valid entry holding a key and the
// lowest-index invalid entry. Used by both the write and lookup paths.
module lut_slot_find #(
  parameter int NR_KEY  = 4,
  parameter int KEY_LEN = 4
) (
  input  logic [KEY_LEN-1:0]         key,
  input  logic [NR_KEY*KEY_LEN-1:0]  keys,
  input  logic [NR_KEY-1:0]          valid,
  output logic                       match,
  output logic [$clog2(NR_KEY)-1:0]  match_idx,
  output logic                       free,
  output logic [$clog2(NR_KEY)-1:0]  free_idx
);

  localparam int IDX_W = $clog2(NR_KEY);

  // Scan from the top down so the last hit written is the lowest index.
  // NOTE: every output gets a default before the loop, otherwise the
  // paths that assign nothing would infer latches.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    free      = 1'b0;
    free_idx  = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid[i] && (keys[i*KEY_LEN +: KEY_LEN] == key)) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_key_table.sv
// Writable associative key/data table. Upsert/delete/clear arrive over a
// valid/ready handshake; contents are driven as a flattened LUT bus and
// can also be queried through a registered one-cycle lookup port.
module mux_key_table
  import mux_key_table_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [1:0]                           wr_op,
  input  logic [KEY_LEN-1:0]                   wr_key,
  input  logic [DATA_LEN-1:0]                  wr_data,
  output logic                                 wr_resp_valid,
  output logic [1:0]                           wr_resp_status,
  input  logic                                 rd_valid,
  input  logic [KEY_LEN-1:0]                   rd_key,
  output logic                                 rd_resp_valid,
  output logic                                 rd_hit,
  output logic [DATA_LEN-1:0]                  rd_data,
  output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [NR_KEY-1:0]                    entry_valid,
  output logic [$clog2(NR_KEY+1)-1:0]          count
);

  localparam int PAIR  = KEY_LEN + DATA_LEN;
  localparam int IDX_W = $clog2(NR_KEY);
  localparam int CNT_W = $clog2(NR_KEY + 1);

  logic [KEY_LEN-1:0]        key_q  [NR_KEY];
  logic [DATA_LEN-1:0]       data_q [NR_KEY];
  logic [NR_KEY-1:0]         valid_q;
  logic [NR_KEY*KEY_LEN-1:0] keys_flat;

  state_e                    state_q, state_d;
  op_e                       op_q;
  logic [KEY_LEN-1:0]        req_key_q;
  logic [DATA_LEN-1:0]       req_data_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      clear_last;

  logic                      wr_match, wr_free;
  logic [IDX_W-1:0]          wr_match_idx, wr_free_idx;
  logic                      rd_match;
  logic [IDX_W-1:0]          rd_match_idx;
  logic                      rd_free_unused;
  logic [IDX_W-1:0]          rd_free_idx_unused;

  assign wr_ready    = (state_q == S_IDLE) && !rst;
  assign clear_last  = (idx_q == IDX_W'(NR_KEY - 1));
  assign entry_valid = valid_q;

  // Flatten stored keys for the searchers and pack the LUT bus; invalid
  // entries are held at zero in storage so they contribute nothing.
  always_comb begin
    keys_flat = '0;
    lut       = '0;
    count     = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      keys_flat[n*KEY_LEN +: KEY_LEN] = key_q[n];
      lut[n*PAIR +: PAIR]             = {key_q[n], data_q[n]};
      count                           = count + CNT_W'(valid_q[n]);
    end
  end

  lut_slot_find #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_wr_find (
    .key       (req_key_q),
    .keys      (keys_flat),
    .valid     (valid_q),
    .match     (wr_match),
    .match_idx (wr_match_idx),
    .free      (wr_free),
    .free_idx  (wr_free_idx)
  );

  lut_slot_find #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_rd_find (
    .key       (rd_key),
    .keys      (keys_flat),
    .valid     (valid_q),
    .match     (rd_match),
    .match_idx (rd_match_idx),
    .free      (rd_free_unused),
    .free_idx  (rd_free_idx_unused)
  );

  // FSM next state: accept in IDLE, one COMMIT cycle or an NR_KEY-cycle sweep.
  // NOTE: combinational logic uses blocking '=', clocked state uses '<='.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (wr_valid && wr_ready)
                  state_d = (op_e'(wr_op) == OP_CLEAR) ? S_CLEAR : S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      S_CLEAR:  if (clear_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request capture, table update and write response.
  // NOTE: the key/data arrays are reset on purpose: the LUT bus must read
  // all-zero straight after reset, so this storage cannot be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NR_KEY; n++) begin
        key_q[n]  <= '0;
        data_q[n] <= '0;
      end
      valid_q        <= '0;
      op_q           <= OP_UPSERT;
      req_key_q      <= '0;
      req_data_q     <= '0;
      idx_q          <= '0;
      wr_resp_valid  <= 1'b0;
      wr_resp_status <= ST_OK_UPDATE;
    end else begin
      wr_resp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_valid) begin
            op_q       <= op_e'(wr_op);
            req_key_q  <= wr_key;
            req_data_q <= wr_data;
            idx_q      <= '0;
          end
        end
        S_COMMIT: begin
          wr_resp_valid <= 1'b1;
          case (op_q)
            OP_UPSERT: begin
              if (wr_match) begin
                data_q[wr_match_idx] <= req_data_q;
                wr_resp_status       <= ST_OK_UPDATE;
              end else if (wr_free) begin
                valid_q[wr_free_idx] <= 1'b1;
                key_q[wr_free_idx]   <= req_key_q;
                data_q[wr_free_idx]  <= req_data_q;
                wr_resp_status       <= ST_OK_ALLOC;
              end else begin
                wr_resp_status <= ST_ERR_FULL;
              end
            end
            OP_DELETE: begin
              if (wr_match) begin
                valid_q[wr_match_idx] <= 1'b0;
                key_q[wr_match_idx]   <= '0;
                data_q[wr_match_idx]  <= '0;
                wr_resp_status        <= ST_OK_UPDATE;
              end else begin
                wr_resp_status <= ST_ERR_MISS;
              end
            end
            default: wr_resp_status <= ST_OK_UPDATE;
          endcase
        end
        S_CLEAR: begin
          valid_q[idx_q] <= 1'b0;
          key_q[idx_q]   <= '0;
          data_q[idx_q]  <= '0;
          idx_q          <= idx_q + IDX_W'(1);
          if (clear_last) begin
            wr_resp_valid  <= 1'b1;
            wr_resp_status <= ST_OK_UPDATE;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered lookup against the table as it stands this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_resp_valid <= 1'b0;
      rd_hit        <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_resp_valid <= rd_valid;
      if (rd_valid) begin
        rd_hit  <= rd_match;
        rd_data <= rd_match ? data_q[rd_match_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_key_table.sv
// Self-checking bench for mux_key_table: directed scenarios followed by
// random operations, all compared against a slot-array reference model.
module tb_mux_key_table;

  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 4;
  localparam int DATA_LEN = 32;
  localparam int PAIR     = KEY_LEN + DATA_LEN;
  localparam int LUT_W    = NR_KEY * PAIR;

  localparam logic [1:0] UPS = 2'b00, DEL = 2'b01, CLR = 2'b10, RSV = 2'b11;
  localparam logic [1:0] OK_UPD = 2'b00, OK_ALC = 2'b01, E_FULL = 2'b10, E_MISS = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [1:0]            wr_op;
  logic [KEY_LEN-1:0]    wr_key;
  logic [DATA_LEN-1:0]   wr_data;
  logic                  wr_resp_valid;
  logic [1:0]            wr_resp_status;
  logic                  rd_valid;
  logic [KEY_LEN-1:0]    rd_key;
  logic                  rd_resp_valid;
  logic                  rd_hit;
  logic [DATA_LEN-1:0]   rd_data;
  logic [LUT_W-1:0]      lut;
  logic [NR_KEY-1:0]     entry_valid;
  logic [2:0]            count;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per table entry.
  logic                m_valid [NR_KEY];
  logic [KEY_LEN-1:0]  m_key   [NR_KEY];
  logic [DATA_LEN-1:0] m_data  [NR_KEY];

  mux_key_table #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_op          (wr_op),
    .wr_key         (wr_key),
    .wr_data        (wr_data),
    .wr_resp_valid  (wr_resp_valid),
    .wr_resp_status (wr_resp_status),
    .rd_valid       (rd_valid),
    .rd_key         (rd_key),
    .rd_resp_valid  (rd_resp_valid),
    .rd_hit         (rd_hit),
    .rd_data        (rd_data),
    .lut            (lut),
    .entry_valid    (entry_valid),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int n = 0; n < NR_KEY; n++) begin
      m_valid[n] = 1'b0;
      m_key[n]   = '0;
      m_data[n]  = '0;
    end
  endfunction

  function automatic logic [LUT_W-1:0] model_lut();
    logic [LUT_W-1:0] r = '0;
    for (int n = 0; n < NR_KEY; n++)
      if (m_valid[n]) r[n*PAIR +: PAIR] = {m_key[n], m_data[n]};
    return r;
  endfunction

  function automatic logic [NR_KEY-1:0] model_mask();
    logic [NR_KEY-1:0] r = '0;
    for (int n = 0; n < NR_KEY; n++) r[n] = m_valid[n];
    return r;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int n = 0; n < NR_KEY; n++) if (m_valid[n]) c++;
    return c;
  endfunction

  function automatic int model_find(input logic [KEY_LEN-1:0] k);
    for (int n = 0; n < NR_KEY; n++) if (m_valid[n] && m_key[n] == k) return n;
    return -1;
  endfunction

  // Apply an operation to the model and return the response it should give.
  function automatic logic [1:0] model_apply(input logic [1:0] op, input logic [KEY_LEN-1:0] k,
                                             input logic [DATA_LEN-1:0] d);
    int hit = model_find(k);
    if (op == UPS) begin
      if (hit >= 0) begin
        m_data[hit] = d;
        return OK_UPD;
      end
      for (int n = 0; n < NR_KEY; n++)
        if (!m_valid[n]) begin
          m_valid[n] = 1'b1;
          m_key[n]   = k;
          m_data[n]  = d;
          return OK_ALC;
        end
      return E_FULL;
    end
    if (op == DEL) begin
      if (hit < 0) return E_MISS;
      m_valid[hit] = 1'b0;
      m_key[hit]   = '0;
      m_data[hit]  = '0;
      return OK_UPD;
    end
    if (op == CLR) model_reset();
    return OK_UPD;
  endfunction

  task automatic check_table(input string tag);
    check({tag, "_lut"}, lut, model_lut());
    check({tag, "_mask"}, entry_valid, model_mask());
    check({tag, "_count"}, count, model_count());
  endtask

  // One full write transaction with a random lookup riding on the accept cycle.
  task automatic do_op(input logic [1:0] op, input logic [KEY_LEN-1:0] k,
                       input logic [DATA_LEN-1:0] d);
    logic [1:0]          exp_st;
    logic [KEY_LEN-1:0]  rk;
    int                  rh;
    logic [DATA_LEN-1:0] exp_rd;
    check("ready_idle", wr_ready, 1'b1);
    rk     = KEY_LEN'($urandom_range(0, 9));
    rh     = model_find(rk);
    exp_rd = (rh >= 0) ? m_data[rh] : '0;
    wr_valid = 1'b1; wr_op = op; wr_key = k; wr_data = d;
    rd_valid = 1'b1; rd_key = rk;
    exp_st = model_apply(op, k, d);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("rd_valid", rd_resp_valid, 1'b1);
    check("rd_hit", rd_hit, rh >= 0);
    check("rd_data", rd_data, exp_rd);
    check("ready_busy", wr_ready, 1'b0);
    check("resp_early", wr_resp_valid, 1'b0);
    if (op == CLR) begin
      for (int i = 1; i < NR_KEY; i++) begin
        tick();
        check("ready_sweep", wr_ready, 1'b0);
        check("resp_sweep", wr_resp_valid, 1'b0);
      end
    end
    tick();
    check("resp_valid", wr_resp_valid, 1'b1);
    check("resp_status", wr_resp_status, exp_st);
    check("ready_back", wr_ready, 1'b1);
    check("rd_idle", rd_resp_valid, 1'b0);
    check_table("post_op");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [LUT_W-1:0]    lut_before;
    logic [DATA_LEN-1:0] d5;
    int                  r;

    rst = 1'b1; wr_valid = 1'b0; wr_op = UPS; wr_key = '0; wr_data = '0;
    rd_valid = 1'b0; rd_key = '0;
    model_reset();
    tick(); tick();
    check("ready_in_rst", wr_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_ready", wr_ready, 1'b1);
    check("rst_resp_valid", wr_resp_valid, 1'b0);
    check("rst_resp_status", wr_resp_status, 2'b00);
    check("rst_rd_valid", rd_resp_valid, 1'b0);
    check("rst_rd_hit", rd_hit, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_lut", lut, '0);
    check("rst_mask", entry_valid, 4'b0000);
    check("rst_count", count, 3'd0);

    // First allocation lands in entry 0.
    do_op(UPS, 4'h3, 32'hDEADBEEF);
    check("alloc_entry0", lut[PAIR-1:0], {4'h3, 32'hDEADBEEF});
    check("alloc_mask", entry_valid, 4'b0001);
    check("alloc_count", count, 3'd1);

    // Overwrite existing key, then look it up.
    do_op(UPS, 4'h3, 32'h1);
    check("upd_count", count, 3'd1);
    check("upd_entry0", lut[PAIR-1:0], {4'h3, 32'h1});
    rd_valid = 1'b1; rd_key = 4'h3;
    tick();
    rd_valid = 1'b0;
    check("lookup3_hit", rd_hit, 1'b1);
    check("lookup3_data", rd_data, 32'h1);
    tick();

    // Fill the table, then overflow it.
    do_op(DEL, 4'h3, 32'h0);
    do_op(UPS, 4'h1, 32'hA0000001);
    do_op(UPS, 4'h2, 32'hA0000002);
    do_op(UPS, 4'h4, 32'hA0000004);
    do_op(UPS, 4'h5, 32'hA0000005);
    lut_before = lut;
    do_op(UPS, 4'h6, 32'hA0000006);
    check("full_lut_same", lut, lut_before);
    check("full_count", count, 3'd4);

    // Delete frees entry 1, which the next allocation reuses.
    do_op(DEL, 4'h2, 32'h0);
    check("del_entry1_zero", lut[2*PAIR-1:PAIR], '0);
    do_op(UPS, 4'h9, 32'hA0000009);
    check("reuse_entry1_key", lut[2*PAIR-1:2*PAIR-KEY_LEN], 4'h9);
    do_op(DEL, 4'h7, 32'h0);
    do_op(RSV, 4'h1, 32'h0);

    // Clear sweep with lookups while it runs.
    d5 = m_data[model_find(4'h5)];
    check("clr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_op = CLR;
    tick();
    wr_valid = 1'b0;
    check("clr_c1_ready", wr_ready, 1'b0);
    check("clr_c1_count", count, 3'd4);
    tick();
    check("clr_c2_ready", wr_ready, 1'b0);
    check("clr_c2_count", count, 3'd3);
    check("clr_c2_entry0", lut[PAIR-1:0], '0);
    rd_valid = 1'b1; rd_key = 4'h1;
    tick();
    check("clr_rd1_hit", rd_hit, 1'b0);
    check("clr_rd1_data", rd_data, 32'h0);
    check("clr_c3_ready", wr_ready, 1'b0);
    check("clr_c3_count", count, 3'd2);
    rd_key = 4'h5;
    tick();
    rd_valid = 1'b0;
    check("clr_rd5_hit", rd_hit, 1'b1);
    check("clr_rd5_data", rd_data, d5);
    check("clr_c4_ready", wr_ready, 1'b0);
    check("clr_c4_resp", wr_resp_valid, 1'b0);
    tick();
    model_reset();
    check("clr_resp_valid", wr_resp_valid, 1'b1);
    check("clr_resp_status", wr_resp_status, OK_UPD);
    check("clr_ready_back", wr_ready, 1'b1);
    check_table("clr_done");

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 15);
      if (r <= 7)       do_op(UPS, KEY_LEN'($urandom_range(0, 9)), $urandom);
      else if (r <= 12) do_op(DEL, KEY_LEN'($urandom_range(0, 9)), $urandom);
      else if (r <= 14) do_op(RSV, KEY_LEN'($urandom_range(0, 9)), $urandom);
      else              do_op(CLR, '0, '0);
    end

    // Reset during the COMMIT cycle abandons the upsert.
    wr_valid = 1'b1; wr_op = UPS; wr_key = 4'hA; wr_data = 32'h12345678;
    tick();
    wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_resp", wr_resp_valid, 1'b0);
    check("midrst_ready", wr_ready, 1'b0);
    rst = 1'b0;
    model_reset();
    tick();
    check("midrst_ready_after", wr_ready, 1'b1);
    check("midrst_resp_after", wr_resp_valid, 1'b0);
    check_table("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
